// File: rtl/overdrive_drive_gain.sv
// Drive (pre-gain) stage of the overdrive chain: ramped gain multiply, symmetric saturation,
// 2-cycle pipeline with valid strobe, feeding the soft-clip LUT.
//
// state | meaning
// IDLE  | gain_cur equals the last sampled drive_target
// UP    | gain_cur climbing toward a higher target
// DOWN  | gain_cur falling toward a lower target
module overdrive_drive_gain #(
    parameter int WIDTH     = 24,
    parameter int GAIN_W    = 12,
    parameter int GAIN_FRAC = 8,
    parameter int RAMP_STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [WIDTH-1:0]  in_sample,
    input  logic        [GAIN_W-1:0] drive_target,
    input  logic                     bypass,
    output logic                     out_valid,
    output logic signed [WIDTH-1:0]  out_sample,
    output logic                     clip_flag,
    output logic        [GAIN_W-1:0] gain_cur
);

    localparam int PW = WIDTH + GAIN_W + 1;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1 << GAIN_FRAC);
    localparam logic [GAIN_W-1:0] STEP  = GAIN_W'(RAMP_STEP);
    localparam logic signed [PW-1:0] SAT_HI = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_LO = -SAT_HI;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [GAIN_W-1:0]    gain_nxt;
    logic [GAIN_W-1:0]    up_diff, dn_diff;
    logic                 tgt_gt, tgt_lt, up_hits, dn_hits;

    logic                 s1_valid;
    logic                 s1_bypass;
    logic signed [PW-1:0] s1_prod;
    logic signed [WIDTH-1:0] s1_raw;
    logic signed [PW-1:0] prod_a, prod_g, shifted;
    logic signed [WIDTH-1:0] sat_val;
    logic                 sat_clip;

    // ---------------- gain ramp ----------------
    assign tgt_gt  = drive_target > gain_cur;
    assign tgt_lt  = drive_target < gain_cur;
    assign up_diff = drive_target - gain_cur;
    assign dn_diff = gain_cur - drive_target;
    assign up_hits = up_diff <= STEP;
    assign dn_hits = dn_diff <= STEP;

    always_comb begin
        state_nxt = state;
        gain_nxt  = gain_cur;
        if (in_valid) begin
            // Step never exceeds the remaining distance, so the ramp cannot overshoot or wrap.
            if (tgt_gt)
                gain_nxt = up_hits ? drive_target : gain_cur + STEP;
            else if (tgt_lt)
                gain_nxt = dn_hits ? drive_target : gain_cur - STEP;

            case (state)
                IDLE: begin
                    if (tgt_gt)
                        state_nxt = up_hits ? IDLE : UP;
                    else if (tgt_lt)
                        state_nxt = dn_hits ? IDLE : DOWN;
                end
                UP: begin
                    if (tgt_lt)
                        state_nxt = dn_hits ? IDLE : DOWN;
                    else
                        state_nxt = (tgt_gt && !up_hits) ? UP : IDLE;
                end
                DOWN: begin
                    if (tgt_gt)
                        state_nxt = up_hits ? IDLE : UP;
                    else
                        state_nxt = (tgt_lt && !dn_hits) ? DOWN : IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gain_cur <= UNITY;
        end else begin
            state    <= state_nxt;
            gain_cur <= gain_nxt;
        end
    end

    // ---------------- stage 1: multiply by the pre-update gain ----------------
    assign prod_a = PW'(in_sample);
    assign prod_g = PW'($signed({1'b0, gain_cur}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_bypass <= 1'b0;
            s1_prod   <= '0;
            s1_raw    <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_bypass <= bypass;
                s1_prod   <= prod_a * prod_g;
                s1_raw    <= in_sample;
            end
        end
    end

    // ---------------- stage 2: scale back and saturate symmetrically ----------------
    assign shifted = s1_prod >>> GAIN_FRAC;

    always_comb begin
        sat_val  = shifted[WIDTH-1:0];
        sat_clip = 1'b0;
        if (s1_bypass) begin
            sat_val = s1_raw;
        end else if (shifted > SAT_HI) begin
            sat_val  = SAT_HI[WIDTH-1:0];
            sat_clip = 1'b1;
        end else if (shifted < SAT_LO) begin
            sat_val  = SAT_LO[WIDTH-1:0];
            sat_clip = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
            clip_flag  <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sample <= sat_val;
                clip_flag  <= sat_clip;
            end
        end
    end

endmodule

// File: tb/tb_overdrive_drive_gain.sv
// Directed bench for overdrive_drive_gain: latency, saturation, bypass, gain ramp and reset.
module tb_overdrive_drive_gain;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic signed [23:0] in_sample;
    logic [11:0]        drive_target;
    logic               bypass;
    logic               out_valid;
    logic signed [23:0] out_sample;
    logic               clip_flag;
    logic [11:0]        gain_cur;

    int n_assert = 0;
    int n_fail   = 0;

    overdrive_drive_gain dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_sample    (in_sample),
        .drive_target (drive_target),
        .bypass       (bypass),
        .out_valid    (out_valid),
        .out_sample   (out_sample),
        .clip_flag    (clip_flag),
        .gain_cur     (gain_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One-cycle strobe driven on the falling edge.
    task automatic strobe(input logic signed [23:0] s, input logic [11:0] t, input logic b);
        @(negedge clk);
        in_valid     = 1'b1;
        in_sample    = s;
        drive_target = t;
        bypass       = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_chk(input string tag, input logic signed [23:0] s, input logic [11:0] t,
                            input logic b, input logic signed [31:0] exp_out, input logic exp_clip);
        strobe(s, t, b);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_out"}, out_sample, exp_out);
        chk({tag, "_clip"}, clip_flag, exp_clip);
    endtask

    task automatic ramp(input logic [11:0] t, input int n);
        @(negedge clk);
        in_valid     = 1'b1;
        in_sample    = '0;
        bypass       = 1'b0;
        drive_target = t;
        repeat (n) @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic signed [23:0] s5_in   [4];
    logic               s5_byp  [4];
    logic signed [31:0] s5_exp  [4];
    logic               s5_clip [4];

    initial begin
        in_valid     = 1'b0;
        in_sample    = '0;
        drive_target = 12'd256;
        bypass       = 1'b0;
        rst_n        = 1'b1;
        #2;
        do_reset();

        // reset state
        chk("rst_valid", out_valid, 0);
        chk("rst_out", out_sample, 0);
        chk("rst_clip", clip_flag, 0);
        chk("rst_gain", gain_cur, 256);

        // 1: unity pass, exact 2-cycle latency, one-cycle strobe, hold
        strobe(24'sd1048576, 12'd256, 1'b0);
        chk("t1_lat1", out_valid, 0);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_out", out_sample, 1048576);
        chk("t1_clip", clip_flag, 0);
        @(negedge clk);
        chk("t1_pulse", out_valid, 0);
        chk("t1_hold", out_sample, 1048576);

        // 2: ramp unity -> 1024 in 768 strobes, then positive clip
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_sample = '0; bypass = 1'b0; drive_target = 12'd1024;
        @(negedge clk);
        chk("t2_first_step", gain_cur, 257);
        repeat (766) @(negedge clk);
        chk("t2_almost", gain_cur, 1023);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t2_gain", gain_cur, 1024);
        send_chk("t2_pclip", 24'sd3000000, 12'd1024, 1'b0, 8388607, 1'b1);
        chk("t2_gain_hold", gain_cur, 1024);

        // 3: symmetric negative clip at unity; floor rounding at half gain
        do_reset();
        send_chk("t3_nclip", -24'sd8388608, 12'd256, 1'b0, -8388607, 1'b1);
        ramp(12'd128, 128);
        chk("t3_gain", gain_cur, 128);
        send_chk("t3_neg3", -24'sd3, 12'd128, 1'b0, -2, 1'b0);
        send_chk("t3_pos3", 24'sd3, 12'd128, 1'b0, 1, 1'b0);

        // 4: ramp up, reverse mid-ramp, settle without overshoot
        do_reset();
        ramp(12'd512, 44);
        chk("t4_gain300", gain_cur, 300);
        @(negedge clk);
        in_valid = 1'b1; drive_target = 12'd280;
        repeat (10) @(negedge clk);
        chk("t4_gain290", gain_cur, 290);
        repeat (15) @(negedge clk);
        in_valid = 1'b0;
        chk("t4_gain280", gain_cur, 280);
        drive_target = 12'd500;
        repeat (3) @(negedge clk);
        chk("t4_no_strobe", gain_cur, 280);

        // 5: back-to-back strobes with bypass toggling while the gain ramps 256 -> 260
        do_reset();
        s5_in[0] = -24'sd8388608; s5_byp[0] = 1'b1; s5_exp[0] = -8388608; s5_clip[0] = 1'b0;
        s5_in[1] = -24'sd8388608; s5_byp[1] = 1'b0; s5_exp[1] = -8388607; s5_clip[1] = 1'b1;
        s5_in[2] = 24'sd1000;     s5_byp[2] = 1'b1; s5_exp[2] = 1000;     s5_clip[2] = 1'b0;
        s5_in[3] = 24'sd100;      s5_byp[3] = 1'b0; s5_exp[3] = 101;      s5_clip[3] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk($sformatf("t5_valid%0d", c - 2), out_valid, 1);
                chk($sformatf("t5_out%0d", c - 2), out_sample, s5_exp[c - 2]);
                chk($sformatf("t5_clip%0d", c - 2), clip_flag, s5_clip[c - 2]);
            end
            if (c < 4) begin
                in_valid = 1'b1; in_sample = s5_in[c]; bypass = s5_byp[c]; drive_target = 12'd512;
            end else begin
                in_valid = 1'b0; bypass = 1'b0;
            end
        end
        chk("t5_gain", gain_cur, 260);

        // 6: reset with two samples in flight
        @(negedge clk);
        in_valid = 1'b1; in_sample = 24'sd5000; bypass = 1'b0; drive_target = 12'd512;
        @(negedge clk);
        in_sample = 24'sd6000;
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t6_gain_in_rst", gain_cur, 256);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("t6_novalid%0d", c), out_valid, 0);
        end
        chk("t6_gain", gain_cur, 256);
        chk("t6_out", out_sample, 0);
        chk("t6_clip", clip_flag, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
